// File: rtl/uart_rx_param_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- shared definitions for the parameterised UART receiver.
//
// Purpose : receiver FSM state type, bit-timing derivation from the clock
//           and baud rate, and the legal ranges of the receiver parameters.
// Ports   : none (package).
// Config  : UART_RX_PARITY_EN (consumed by the receiver, not by this file).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int unsigned DATA_BITS_MIN  = 5;
    localparam int unsigned DATA_BITS_MAX  = 8;
    localparam int unsigned STOP_BITS_MIN  = 1;
    localparam int unsigned STOP_BITS_MAX  = 2;
    localparam int unsigned FIFO_DEPTH_MIN = 2;

    // Clock cycles per bit on the wire.
    function automatic int unsigned symbolEdgeTime(input int unsigned clockFreq,
                                                   input int unsigned baudRate);
        return clockFreq / baudRate;
    endfunction

    // Offset of the mid-bit sample point within one bit period.
    function automatic int unsigned sampleTime(input int unsigned clockFreq,
                                               input int unsigned baudRate);
        return symbolEdgeTime(clockFreq, baudRate) / 2;
    endfunction

    function automatic bit isPow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// ---------------------------------------------------------------------------
// uart_rx_param_if -- line and consumer-side signals of the UART receiver.
//
// Purpose : bundles the serial line, the receive-FIFO head handshake and the
//           status flags into one port.
// Signals : serial_in      UART line, idle high
//           data_out       head-of-FIFO character
//           data_out_valid FIFO not empty
//           data_out_ready consumer takes the head entry
//           frame_err      head entry had a low stop bit
//           parity_err     head entry failed parity
//           overrun        sticky: a character was dropped
//           overrun_clr    clears overrun
// Modports: master = receiver, slave = line driver / consumer.
// Config  : UART_RX_PARITY_EN affects only the receiver behind this port.
// ---------------------------------------------------------------------------
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);

    logic                 serial_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 overrun_clr;

    modport master (
        input  serial_in,
        input  data_out_ready,
        input  overrun_clr,
        output data_out,
        output data_out_valid,
        output frame_err,
        output parity_err,
        output overrun
    );

    modport slave (
        output serial_in,
        output data_out_ready,
        output overrun_clr,
        input  data_out,
        input  data_out_valid,
        input  frame_err,
        input  parity_err,
        input  overrun
    );

endinterface

// File: rtl/uart_rx_param_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo -- small synchronous FIFO holding received characters.
//
// Purpose : DEPTH-entry FIFO (DEPTH a power of two) with an occupancy count.
// Ports   : clk      clock, rising edge
//           rst      synchronous reset, active low
//           push_i   write wdata_i (ignored when full unless popping too)
//           wdata_i  entry to write
//           pop_i    remove head entry (ignored when empty)
//           rdata_o  head entry
//           full_o   DEPTH entries held
//           empty_o  no entries held
// Config  : none.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rdPtr_q];

    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // accept a push when it is also being popped.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked by the receiver while empty.
    always_ff @(posedge clk) begin
        if (rst && doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param -- parameterised UART receiver with a receive FIFO.
//
// Purpose : oversamples serial_in with the system clock, decodes start,
//           DATA_BITS data bits (LSB first), optional parity and STOP_BITS
//           stop bits, and queues {parity flag, frame flag, data} entries.
// Ports   : clk  clock, rising edge
//           rst  synchronous reset, active low
//           bus  uart_rx_param_if.master (line, FIFO head handshake, flags)
// Config  : UART_RX_PARITY_EN -- when defined a parity bit follows the data
//           bits and parity_err is live; otherwise parity_err is tied 0.
// ---------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    uart_rx_param_if.master      bus
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbolEdgeTime(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SAMPLE_TIME      = sampleTime(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam int unsigned BIT_W            = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    localparam int unsigned ENTRY_W          = DATA_BITS + 2;
`else
    localparam int unsigned ENTRY_W          = DATA_BITS + 1;
`endif

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
        FIFO_DEPTH < FIFO_DEPTH_MIN || !isPow2(FIFO_DEPTH) ||
        PARITY_ODD > 1 || SAMPLE_TIME < 1) begin : gBadParams
        $error("uart_rx_param: illegal parameter combination");
    end

    rx_state_e            state_q, state_d;
    logic                 sync1_q;
    logic                 rx_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
    logic                 stopCnt_q, stopCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_q, frame_d;
`ifdef UART_RX_PARITY_EN
    logic                 parityErr_q, parityErr_d;
`endif
    logic                 overrun_q, overrun_d;
    logic                 midBit;
    logic                 bitEdge;
    logic                 push;
    logic [ENTRY_W-1:0]   pushWord;
    logic [ENTRY_W-1:0]   headWord;
    logic                 fifoFull;
    logic                 fifoEmpty;

    // Two-flop synchroniser; resets to the idle line level so no false
    // start bit is seen on reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            sync1_q <= bus.serial_in;
            rx_q    <= sync1_q;
        end
    end

    assign midBit  = (cnt_q == CNT_W'(SAMPLE_TIME - 1));
    assign bitEdge = (cnt_q == CNT_W'(SYMBOL_EDGE_TIME - 1));

    // Bit-timing counter restarts at every symbol edge. The entry is pushed
    // at the mid-bit sample of the last stop bit and the FSM returns to IDLE
    // immediately, leaving half a bit of slack to catch the next start edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bitCnt_d    = bitCnt_q;
        stopCnt_d   = stopCnt_q;
        shift_d     = shift_q;
        frame_d     = frame_q;
`ifdef UART_RX_PARITY_EN
        parityErr_d = parityErr_q;
`endif
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_q) begin
                    state_d     = START;
                    bitCnt_d    = '0;
                    stopCnt_d   = 1'b0;
                    frame_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
                    parityErr_d = 1'b0;
`endif
                end
            end
            START: begin
                if (midBit && rx_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bitEdge) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (midBit) begin
                    shift_d = {rx_q, shift_q[DATA_BITS-1:1]};
                end
                if (bitEdge) begin
                    cnt_d = '0;
                    if (bitCnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bitCnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d  = PARITY;
`else
                        state_d  = STOP;
`endif
                    end else begin
                        bitCnt_d = bitCnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (midBit) begin
                    parityErr_d = ((^shift_q) ^ rx_q) != (PARITY_ODD != 0);
                end
                if (bitEdge) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
            end
`endif
            STOP: begin
                if (midBit) begin
                    frame_d = frame_q | ~rx_q;
                    if (stopCnt_q == 1'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                if (bitEdge) begin
                    cnt_d     = '0;
                    stopCnt_d = stopCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitCnt_q    <= '0;
            stopCnt_q   <= 1'b0;
            shift_q     <= '0;
            frame_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitCnt_q    <= bitCnt_d;
            stopCnt_q   <= stopCnt_d;
            shift_q     <= shift_d;
            frame_q     <= frame_d;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= parityErr_d;
`endif
        end
    end

    // frame_d already folds in the stop sample taken in the push cycle.
`ifdef UART_RX_PARITY_EN
    assign pushWord = {parityErr_q, frame_d, shift_q};
`else
    assign pushWord = {frame_d, shift_q};
`endif

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (pushWord),
        .pop_i   (bus.data_out_ready),
        .rdata_o (headWord),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // A push that the FIFO cannot absorb sets the flag; setting wins over
    // a clear requested in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (push && fifoFull && !bus.data_out_ready) begin
            overrun_d = 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    // Head fields are forced to zero while empty so stale storage never
    // reaches the outputs.
    assign bus.data_out_valid = !fifoEmpty;
    assign bus.data_out       = fifoEmpty ? '0 : headWord[DATA_BITS-1:0];
    assign bus.frame_err      = !fifoEmpty && headWord[DATA_BITS];
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err     = !fifoEmpty && headWord[DATA_BITS+1];
`else
    assign bus.parity_err     = 1'b0;
`endif
    assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param -- self-checking bench for uart_rx_param.
//
// Purpose : serialises characters onto the line, predicts each received
//           entry from the UART framing rules and a FIFO-capacity model,
//           and compares the FIFO head against the predictions in a
//           separate monitor process. A 10 MHz clock keeps characters short.
// Config  : honours UART_RX_PARITY_EN (parity bit sent and predicted).
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int unsigned CLOCK_FREQ = 10_000_000;
    localparam int unsigned BAUD_RATE  = 115_200;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned PARITY_ODD = 0;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 frame;
        logic                 perr;
    } word_t;

    word_t sb[$];
    word_t monExp;
    int    numVectors  = 0;
    int    numFails    = 0;
    int    validCycles = 0;
    int    readyMode   = 1;
    logic  expOverrun  = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_rx_param #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_BITS  (DATA_BITS),
        .STOP_BITS  (STOP_BITS),
        .PARITY_ODD (PARITY_ODD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numVectors++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input int unsigned cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input logic b);
        bus.serial_in = b;
        idle(BIT_CYCLES);
    endtask

    // Predict the entry from the framing rules, then put the frame on the
    // line. When the FIFO would already hold FIFO_DEPTH unread words the
    // character is expected to be dropped and overrun raised.
    task automatic applyStimulus(input logic [DATA_BITS-1:0] data, input bit stopBad,
                                 input bit parityBad);
        word_t w;
        logic  parBit;
        parBit = 1'(($countones(data) % 2) ^ PARITY_ODD) ^ parityBad;
        w.data  = data;
        w.frame = stopBad;
`ifdef UART_RX_PARITY_EN
        w.perr  = ((($countones(data) + int'(parBit)) % 2) != PARITY_ODD);
`else
        w.perr  = 1'b0;
`endif
        if (sb.size() >= FIFO_DEPTH) begin
            expOverrun = 1'b1;
        end else begin
            sb.push_back(w);
        end
        driveBit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) begin
            driveBit(data[i]);
        end
`ifdef UART_RX_PARITY_EN
        driveBit(parBit);
`endif
        for (int s = 0; s < STOP_BITS; s++) begin
            driveBit((stopBad && s == STOP_BITS - 1) ? 1'b0 : 1'b1);
        end
        bus.serial_in = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       bus.data_out_ready = 1'b0;
            1:       bus.data_out_ready = 1'b1;
            default: bus.data_out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: every accepted head entry is matched against the oldest
    // prediction.
    always @(negedge clk) begin
        if (bus.data_out_valid) begin
            validCycles++;
        end
        if (rst && bus.data_out_valid && bus.data_out_ready) begin
            if (sb.size() == 0) begin
                numVectors++;
                numFails++;
                $display("[TB] FAIL unexpected_word: got data 0x%0h, expected no word at %0t",
                         bus.data_out, $time);
            end else begin
                monExp = sb.pop_front();
                checkOutput("data_out",   32'(bus.data_out),   32'(monExp.data));
                checkOutput("frame_err",  32'(bus.frame_err),  32'(monExp.frame));
                checkOutput("parity_err", 32'(bus.parity_err), 32'(monExp.perr));
            end
        end
    end

    initial begin
        logic [DATA_BITS-1:0] partial;
        bus.serial_in   = 1'b1;
        bus.overrun_clr = 1'b0;
        rst             = 1'b0;
        readyMode       = 1;

        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid",   32'(bus.data_out_valid), 0);
        checkOutput("reset_data",    32'(bus.data_out),       0);
        checkOutput("reset_frame",   32'(bus.frame_err),      0);
        checkOutput("reset_parity",  32'(bus.parity_err),     0);
        checkOutput("reset_overrun", 32'(bus.overrun),        0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(BIT_CYCLES);

        $display("[TB] clean character 0xA5");
        validCycles = 0;
        applyStimulus(8'hA5, 1'b0, 1'b0);
        idle(BIT_CYCLES);
        checkOutput("a5_valid_cycles", 32'(validCycles), 1);

        $display("[TB] short low glitch, then a character right after");
        validCycles   = 0;
        bus.serial_in = 1'b0;
        idle(BIT_CYCLES / 4);
        bus.serial_in = 1'b1;
        idle(BIT_CYCLES / 2 + 2);
        checkOutput("glitch_no_push", 32'(validCycles), 0);
        applyStimulus(8'h5A, 1'b0, 1'b0);
        idle(BIT_CYCLES);
        checkOutput("after_glitch_valid_cycles", 32'(validCycles), 1);

        $display("[TB] framing error then clean character");
        applyStimulus(8'h3C, 1'b1, 1'b0);
        idle(BIT_CYCLES);
        applyStimulus(8'h55, 1'b0, 1'b0);
        idle(BIT_CYCLES);

        $display("[TB] overrun with consumer stalled");
        readyMode = 0;
        idle(2);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(DATA_BITS'(i), 1'b0, 1'b0);
            idle(BIT_CYCLES);
        end
        checkOutput("overrun_set",     32'(bus.overrun),        32'(expOverrun));
        checkOutput("stalled_valid",   32'(bus.data_out_valid), 1);
        checkOutput("stalled_head",    32'(bus.data_out),       32'(sb[0].data));
        readyMode = 1;
        idle(FIFO_DEPTH + 3);
        checkOutput("drained_words",   32'(sb.size()),          0);
        checkOutput("drained_valid",   32'(bus.data_out_valid), 0);
        checkOutput("overrun_sticky",  32'(bus.overrun),        32'(expOverrun));
        bus.overrun_clr = 1'b1;
        idle(1);
        bus.overrun_clr = 1'b0;
        expOverrun      = 1'b0;
        checkOutput("overrun_cleared", 32'(bus.overrun),        32'(expOverrun));

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity checks on 0x07");
        applyStimulus(8'h07, 1'b0, 1'b1);
        idle(BIT_CYCLES);
        applyStimulus(8'h07, 1'b0, 1'b0);
        idle(BIT_CYCLES);
`endif

        $display("[TB] reset in the middle of a character");
        readyMode = 0;
        idle(2);
        applyStimulus(8'h6E, 1'b0, 1'b0);
        idle(BIT_CYCLES);
        partial = DATA_BITS'($urandom);
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) begin
            driveBit(partial[i]);
        end
        bus.serial_in = partial[4];
        idle(BIT_CYCLES / 2);
        rst = 1'b0;
        idle(1);
        rst           = 1'b1;
        bus.serial_in = 1'b1;
        sb.delete();
        expOverrun    = 1'b0;
        checkOutput("midreset_valid",   32'(bus.data_out_valid), 0);
        checkOutput("midreset_data",    32'(bus.data_out),       0);
        checkOutput("midreset_frame",   32'(bus.frame_err),      0);
        checkOutput("midreset_parity",  32'(bus.parity_err),     0);
        checkOutput("midreset_overrun", 32'(bus.overrun),        32'(expOverrun));
        validCycles = 0;
        idle(12 * BIT_CYCLES);
        checkOutput("midreset_quiet", 32'(validCycles), 0);
        readyMode = 1;
        idle(2);
        applyStimulus(8'h81, 1'b0, 1'b0);
        idle(BIT_CYCLES);

        $display("[TB] random characters with random consumer stalls");
        readyMode = 2;
        for (int n = 0; n < 16; n++) begin
            applyStimulus(DATA_BITS'($urandom), $urandom_range(0, 4) == 0,
                          $urandom_range(0, 3) == 0);
            idle(BIT_CYCLES + $urandom_range(0, BIT_CYCLES));
        end
        readyMode = 1;
        idle(2 * BIT_CYCLES);
        checkOutput("all_words_received", 32'(sb.size()), 0);
        checkOutput("final_overrun",      32'(bus.overrun), 32'(expOverrun));

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numFails);
        $finish;
    end

endmodule
